// File: rtl/find_next_hop.sv
// find_next_hop: walks this node's neighbour table in node memory and reports
// the best-Q next hop and the first in-cluster sink neighbour.
// Optional feature macro: FIND_NEXT_HOP_EXPLORE_EN. When it is defined, an
// epsilon-style random override can pick the next hop.
//
// Handshake: start is a level request that is sampled only in IDLE. done rises
// when the results are valid. While start stays high, done and all results are
// held. When start is low in DONE, the block returns to IDLE and done drops.
// Results keep their values until the next accepted start.
module find_next_hop #(
    parameter int          MAX_NEIGH  = 16,
    parameter logic [15:0] NO_NODE    = 16'd65,
    parameter logic [15:0] HDR_ADDR   = 16'h010,
    parameter logic [15:0] NEIGH_BASE = 16'h020,
    parameter logic [7:0]  EPSILON    = 8'd26
) (
    input  logic        clock,
    input  logic        nrst,
    input  logic        start,
    input  logic [15:0] data_in,
    input  logic [15:0] rng_in,
    output logic        rd_en,
    output logic [15:0] address,
    output logic [15:0] nexthop,
    output logic [15:0] nextsinks,
    output logic [15:0] bestq,
    output logic        explored,
    output logic        done,
    output logic [3:0]  dbg_state_o
);

    localparam int IW = $clog2(MAX_NEIGH) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_HDR_CNT, S_HDR_MYQ, S_HDR_MYCL,
        S_E_ID, S_E_Q, S_E_CL, S_E_FL, S_FINISH, S_DONE
    } state_t;

    state_t        state_q;
    logic          phase_q;      // 0 = ISSUE cycle, 1 = CAPTURE cycle
    logic [IW-1:0] idx_q;
    logic [IW-1:0] n_q;
    logic [15:0]   best_q;
    logic [15:0]   cand_q;
    logic [15:0]   mycl_q;
    logic [15:0]   eid_q;
    logic [15:0]   eq_q;
    logic [15:0]   ecl_q;
    logic          rd_en_q;
    logic [15:0]   address_q;
    logic [15:0]   nexthop_q;
    logic [15:0]   nextsinks_q;
    logic [15:0]   bestq_q;
    logic          done_q;
    logic [IW-1:0] idx_nxt;

    assign idx_nxt     = idx_q + 1'b1;
    assign rd_en       = rd_en_q;
    assign address     = address_q;
    assign nexthop     = nexthop_q;
    assign nextsinks   = nextsinks_q;
    assign bestq       = bestq_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

`ifdef FIND_NEXT_HOP_EXPLORE_EN
    logic [7:0]  rnd_lo_q;
    logic [7:0]  exp_idx_q;
    logic [15:0] exp_id_q;
    logic [15:0] exp_qv_q;
    logic        explored_q;
    logic        explore_hit;

    // The random override applies only when the drawn index lies inside the scanned table.
    assign explore_hit = (rnd_lo_q < EPSILON) && ({8'd0, exp_idx_q} < 16'(n_q));
    assign explored    = explored_q;
`else
    logic unused_explore;

    assign explored       = 1'b0;
    assign unused_explore = ^{rng_in, EPSILON};
`endif

    // This function builds the word address of one field in neighbour entry i.
    function automatic logic [15:0] entry_addr(input logic [IW-1:0] i, input logic [1:0] f);
        return NEIGH_BASE + {{(14-IW){1'b0}}, i, 2'b00} + {14'd0, f};
    endfunction

    // The scan FSM does one ISSUE/CAPTURE read pair per state, and all of its outputs are registered.
    always_ff @(posedge clock) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            phase_q     <= 1'b0;
            idx_q       <= '0;
            n_q         <= '0;
            best_q      <= '0;
            cand_q      <= NO_NODE;
            mycl_q      <= '0;
            eid_q       <= '0;
            eq_q        <= '0;
            ecl_q       <= '0;
            rd_en_q     <= 1'b0;
            address_q   <= '0;
            nexthop_q   <= NO_NODE;
            nextsinks_q <= NO_NODE;
            bestq_q     <= '0;
            done_q      <= 1'b0;
`ifdef FIND_NEXT_HOP_EXPLORE_EN
            rnd_lo_q    <= '0;
            exp_idx_q   <= '0;
            exp_id_q    <= '0;
            exp_qv_q    <= '0;
            explored_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_HDR_CNT;
                        phase_q     <= 1'b0;
                        rd_en_q     <= 1'b1;
                        address_q   <= HDR_ADDR;
                        nexthop_q   <= NO_NODE;
                        nextsinks_q <= NO_NODE;
                        bestq_q     <= '0;
`ifdef FIND_NEXT_HOP_EXPLORE_EN
                        rnd_lo_q    <= rng_in[7:0];
                        exp_idx_q   <= rng_in[15:8] & 8'(MAX_NEIGH - 1);
                        explored_q  <= 1'b0;
`endif
                    end
                end
                S_FINISH: begin
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                    end else begin
                        phase_q   <= 1'b0;
                        nexthop_q <= cand_q;
                        bestq_q   <= best_q;
`ifdef FIND_NEXT_HOP_EXPLORE_EN
                        if (explore_hit) begin
                            nexthop_q  <= exp_id_q;
                            bestq_q    <= exp_qv_q;
                            explored_q <= 1'b1;
                        end
`endif
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                        rd_en_q <= 1'b0;
                    end else begin
                        // On CAPTURE, register data_in and issue the next read in the same edge.
                        phase_q <= 1'b0;
                        rd_en_q <= 1'b1;
                        case (state_q)
                            S_HDR_CNT: begin
                                n_q       <= (data_in > 16'(MAX_NEIGH)) ? IW'(MAX_NEIGH) : data_in[IW-1:0];
                                state_q   <= S_HDR_MYQ;
                                address_q <= HDR_ADDR + 16'd1;
                            end
                            S_HDR_MYQ: begin
                                best_q    <= data_in;
                                cand_q    <= NO_NODE;
                                state_q   <= S_HDR_MYCL;
                                address_q <= HDR_ADDR + 16'd2;
                            end
                            S_HDR_MYCL: begin
                                mycl_q <= data_in;
                                idx_q  <= '0;
                                if (n_q == '0) begin
                                    state_q <= S_FINISH;
                                    rd_en_q <= 1'b0;
                                end else begin
                                    state_q   <= S_E_ID;
                                    address_q <= entry_addr('0, 2'd0);
                                end
                            end
                            S_E_ID: begin
                                eid_q     <= data_in;
                                state_q   <= S_E_Q;
                                address_q <= entry_addr(idx_q, 2'd1);
                            end
                            S_E_Q: begin
                                eq_q      <= data_in;
`ifdef FIND_NEXT_HOP_EXPLORE_EN
                                if (16'(idx_q) == {8'd0, exp_idx_q}) begin
                                    exp_id_q <= eid_q;
                                    exp_qv_q <= data_in;
                                end
`endif
                                state_q   <= S_E_CL;
                                address_q <= entry_addr(idx_q, 2'd2);
                            end
                            S_E_CL: begin
                                ecl_q     <= data_in;
                                state_q   <= S_E_FL;
                                address_q <= entry_addr(idx_q, 2'd3);
                            end
                            S_E_FL: begin
                                // A strict compare keeps the earliest index, or self, on ties.
                                if (eq_q > best_q) begin
                                    best_q <= eq_q;
                                    cand_q <= eid_q;
                                end
                                if (data_in[0] && (ecl_q == mycl_q) && (nextsinks_q == NO_NODE)) begin
                                    nextsinks_q <= eid_q;
                                end
                                if (idx_nxt == n_q) begin
                                    state_q <= S_FINISH;
                                    rd_en_q <= 1'b0;
                                end else begin
                                    idx_q     <= idx_nxt;
                                    state_q   <= S_E_ID;
                                    address_q <= entry_addr(idx_nxt, 2'd0);
                                end
                            end
                            default: begin
                                state_q <= S_IDLE;
                                rd_en_q <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_find_next_hop.sv
// tb_find_next_hop: drives find_next_hop against a behavioural node memory
// and compares each scan's results with an independent table-walk model.
module tb_find_next_hop;

    localparam int MAX_NEIGH = 16;
    localparam int NO_NODE   = 65;
    localparam int HDR       = 'h010;
    localparam int NB        = 'h020;
    localparam int EPS       = 26;

    logic        clock = 1'b0;
    logic        nrst  = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data_in = '0;
    logic [15:0] rng_in  = '0;
    logic        rd_en;
    logic [15:0] address;
    logic [15:0] nexthop;
    logic [15:0] nextsinks;
    logic [15:0] bestq;
    logic        explored;
    logic        done;
    logic [3:0]  dbg_state;

    logic [15:0] mem [0:255];
    logic [15:0] exp_q [$];

    int n_checks = 0;
    int n_pass   = 0;
    int reads    = 0;
    int neigh_reads = 0;
    int overlap  = 0;
    logic prev_rd = 1'b0;

    find_next_hop dut (
        .clock       (clock),
        .nrst        (nrst),
        .start       (start),
        .data_in     (data_in),
        .rng_in      (rng_in),
        .rd_en       (rd_en),
        .address     (address),
        .nexthop     (nexthop),
        .nextsinks   (nextsinks),
        .bestq       (bestq),
        .explored    (explored),
        .done        (done),
        .dbg_state_o (dbg_state)
    );

    // This block generates the clock.
    always #5 clock = ~clock;

    // The synchronous memory returns data one cycle after rd_en. The same block also counts reads and overlapping reads.
    always @(posedge clock) begin
        if (rd_en) begin
            data_in <= mem[address[7:0]];
            reads = reads + 1;
            if (address >= 16'(NB)) neigh_reads = neigh_reads + 1;
            if (prev_rd) overlap = overlap + 1;
        end
        prev_rd = rd_en;
    end

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic set_hdr(input int cnt, input int myq, input int mycl);
        mem[HDR] = 16'(cnt);
        mem[HDR+1] = 16'(myq);
        mem[HDR+2] = 16'(mycl);
    endtask

    task automatic set_ent(input int i, input int id, input int q, input int cl, input int fl);
        mem[NB+4*i]   = 16'(id);
        mem[NB+4*i+1] = 16'(q);
        mem[NB+4*i+2] = 16'(cl);
        mem[NB+4*i+3] = 16'(fl);
    endtask

    // The reference model walks the table in mem and pushes the expected scan results.
    task automatic push_expect(input logic [15:0] rng);
        int n;
        int idx;
        logic [15:0] best, cand, sink, nh, bq, ex;
        n = (mem[HDR] > 16'(MAX_NEIGH)) ? MAX_NEIGH : int'(mem[HDR]);
        best = mem[HDR+1];
        cand = 16'(NO_NODE);
        sink = 16'(NO_NODE);
        for (int i = 0; i < n; i++) begin
            if (mem[NB+4*i+1] > best) begin
                best = mem[NB+4*i+1];
                cand = mem[NB+4*i];
            end
            if (mem[NB+4*i+3][0] && mem[NB+4*i+2] == mem[HDR+2] && sink == 16'(NO_NODE))
                sink = mem[NB+4*i];
        end
        nh = cand;
        bq = best;
        ex = 16'd0;
        idx = int'(rng[15:8]) % MAX_NEIGH;
`ifdef FIND_NEXT_HOP_EXPLORE_EN
        if (int'(rng[7:0]) < EPS && idx < n) begin
            nh = mem[NB+4*idx];
            bq = mem[NB+4*idx+1];
            ex = 16'd1;
        end
`endif
        exp_q.push_back(16'(8*n+8));
        exp_q.push_back(nh);
        exp_q.push_back(sink);
        exp_q.push_back(bq);
        exp_q.push_back(ex);
        exp_q.push_back(16'(3+4*n));
        exp_q.push_back(16'(4*n));
        exp_q.push_back(16'd0);
    endtask

    // This task runs one scan, optionally holding start high through DONE, and checks it against the queue.
    task automatic run_scan(input string name, input logic [15:0] rng, input bit hold);
        int cyc;
        bit got;
        logic [15:0] ev [8];
        logic [15:0] av [8];
        string tags [8];
        tags = '{"latency", "nexthop", "nextsinks", "bestq", "explored", "reads", "neigh_reads", "overlap"};
        push_expect(rng);
        @(negedge clock);
        rng_in = rng;
        start = 1'b1;
        reads = 0;
        neigh_reads = 0;
        overlap = 0;
        @(posedge clock);
        #1;
        if (!hold) start = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 400) begin
            @(posedge clock);
            cyc++;
            #1;
            if (done) got = 1'b1;
        end
        av = '{16'(cyc), nexthop, nextsinks, bestq, {15'd0, explored}, 16'(reads), 16'(neigh_reads), 16'(overlap)};
        for (int k = 0; k < 8; k++) begin
            ev[k] = exp_q.pop_front();
            check_val({name, "_", tags[k]}, av[k], ev[k]);
        end
        if (hold) begin
            for (int k = 0; k < 4; k++) begin
                @(posedge clock);
                #1;
                check_val({name, "_hold_done"}, {15'd0, done}, 16'd1);
                check_val({name, "_hold_nexthop"}, nexthop, ev[1]);
            end
            start = 1'b0;
        end
        @(posedge clock);
        #1;
        check_val({name, "_done_clear"}, {15'd0, done}, 16'd0);
        check_val({name, "_nexthop_kept"}, nexthop, ev[1]);
    endtask

    task automatic table1();
        clear_mem();
        set_hdr(3, 10, 2);
        set_ent(0, 5, 20, 2, 0);
        set_ent(1, 7, 40, 3, 0);
        set_ent(2, 9, 40, 2, 0);
    endtask

    initial begin
        clear_mem();
        // This block holds reset for a few cycles and then checks the reset values.
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_done", {15'd0, done}, 16'd0);
        check_val("rst_rd_en", {15'd0, rd_en}, 16'd0);
        check_val("rst_address", address, 16'd0);
        check_val("rst_nexthop", nexthop, 16'(NO_NODE));
        check_val("rst_nextsinks", nextsinks, 16'(NO_NODE));
        check_val("rst_bestq", bestq, 16'd0);
        check_val("rst_explored", {15'd0, explored}, 16'd0);
        nrst = 1'b1;
        @(posedge clock);

        table1();
        run_scan("greedy", 16'h0000, 1'b0);

        clear_mem();
        set_hdr(2, 50, 1);
        set_ent(0, 12, 30, 4, 1);
        set_ent(1, 14, 10, 1, 1);
        run_scan("sink", 16'h0000, 1'b0);

        clear_mem();
        set_hdr(0, 33, 1);
        run_scan("empty", 16'h0000, 1'b0);

        clear_mem();
        set_hdr(40, 5, 0);
        for (int i = 0; i < 40; i++) set_ent(i, 20 + i, (i < 16) ? i : 250, 0, 0);
        set_ent(15, 44, 200, 0, 0);
        run_scan("clamp", 16'h0000, 1'b0);

        // Reset during the first E_Q state must abort the scan.
        table1();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        nrst = 1'b0;
        @(posedge clock);
        #1;
        check_val("midrst_rd_en", {15'd0, rd_en}, 16'd0);
        check_val("midrst_done", {15'd0, done}, 16'd0);
        check_val("midrst_nexthop", nexthop, 16'(NO_NODE));
        check_val("midrst_address", address, 16'd0);
        nrst = 1'b1;
        @(posedge clock);

        run_scan("hold", 16'h0000, 1'b1);

        table1();
        run_scan("explore_hit", 16'h0105, 1'b0);
        run_scan("explore_miss", 16'h0550, 1'b0);
        run_scan("explore_oob", 16'h0805, 1'b0);

        for (int r = 0; r < 6; r++) begin
            clear_mem();
            set_hdr($urandom_range(0, 20), $urandom_range(0, 60), $urandom_range(0, 3));
            for (int i = 0; i < 20; i++)
                set_ent(i, $urandom_range(1, 64), $urandom_range(0, 80), $urandom_range(0, 3), $urandom_range(0, 1));
            run_scan("random", 16'(($urandom_range(0, 255) << 8) | $urandom_range(0, 40)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/find_next_hop.md
Name: find_next_hop

Overview:
Neighbour-table scanner that feeds the action-selection stage. On start it walks this node's neighbour table in node memory and reports:
- the best-Q next hop,
- the first in-cluster sink neighbour, if any.
Outputs nexthop/nextsinks use the codebase sentinel 65 for "none", so the downstream selector schedules aggregation when nexthop == 65.

Parameters:
MAX_NEIGH, 16, max neighbour entries scanned (power of 2); larger stored counts are clamped
NO_NODE, 65, sentinel ID meaning "no hop / no sink"
HDR_ADDR, 16'h010, header base: +0 neighbour count, +1 my Q, +2 my cluster ID
NEIGH_BASE, 16'h020, entry i at NEIGH_BASE+4*i: +0 ID, +1 Q (unsigned), +2 cluster ID, +3 flags (bit0 = sink)
EPSILON, 8'd26, exploration threshold (used only with EXPLORE_EN)

Ports:
clock  in  1  system clock
nrst  in  1  synchronous active-low reset
start  in  1  level request; sampled in IDLE
data_in  in  16  memory read data, valid 1 cycle after address/rd_en
rng_in  in  16  random word from node RNG; ignored without EXPLORE_EN
rd_en  out  1  memory read strobe
address  out  16  memory word address
nexthop  out  16  chosen next-hop ID or NO_NODE
nextsinks  out  16  first in-cluster sink neighbour ID or NO_NODE
bestq  out  16  Q of chosen hop, or my Q if nexthop == NO_NODE
explored  out  1  1 = nexthop picked by exploration
done  out  1  results valid

Behaviour:
- Clock and reset: clock clock; reset nrst, synchronous, active-low.
- Reset values: done=0, rd_en=0, address=0, nexthop=NO_NODE, nextsinks=NO_NODE, bestq=0, explored=0, state=IDLE.
- Reset mid-scan aborts immediately and restores the reset values; no partial results survive.
- Memory reads: every read takes 2 cycles.
  - ISSUE cycle: address driven, rd_en=1.
  - CAPTURE cycle: rd_en=0, data_in registered.
  - No overlapping reads.
- State sequence: IDLE -> HDR_CNT -> HDR_MYQ -> HDR_MYCL -> {E_ID -> E_Q -> E_CL -> E_FL} x N -> FINISH -> DONE.
  - Each listed state is an ISSUE+CAPTURE pair.
  - N = min(count, MAX_NEIGH).
- Start of scan: IDLE with start=1 moves to HDR_CNT and clears nexthop/nextsinks to NO_NODE, bestq to 0, explored to 0.
- After HDR_MYQ: running best = my Q, candidate = NO_NODE.
- Greedy selection, evaluated on E_FL capture:
  - If entry Q > running best (strictly), candidate = entry ID and best = entry Q.
  - Ties keep the earlier index, or self.
- Sink selection: if flags[0]=1, entry cluster == my cluster, and nextsinks == NO_NODE, then nextsinks = entry ID. First match wins.
- count == 0: after the header, go straight to FINISH; nexthop = nextsinks = NO_NODE; bestq = my Q.
- FINISH: loads nexthop/bestq from candidate/best (or the exploration override); goes to DONE.
- Latency: done rises on the clock edge 8*N+8 cycles after the edge that sampled start (count 0: 8 cycles).
- DONE: done=1 and outputs held stable while start=1. When start=0, return to IDLE with done=0; outputs keep their values until the next start.
- A start pulse held for 1 cycle is sufficient.
- address arithmetic: 16-bit, NEIGH_BASE + {i,2'b00} + field; no wrap checking required.

Optional Feature:
Macro: FIND_NEXT_HOP_EXPLORE_EN.
- Defined:
  - rng_in is latched at the start-sampling edge.
  - idx = rng_in[15:8] & (MAX_NEIGH-1).
  - If rng_in[7:0] < EPSILON and idx < N: at FINISH, nexthop = ID of entry idx, bestq = its Q, explored=1. The ID and Q of entry idx are captured during the scan.
  - Otherwise: greedy result, explored=0.
  - Latency is unchanged.
- Not defined: rng_in is ignored, explored is tied to 0, selection is purely greedy.

Test Plan:
1. Greedy selection, no sink. Setup: count=3, myQ=10, myCl=2, entries (ID,Q,Cl,flags) = (5,20,2,0), (7,40,3,0), (9,40,2,0); start 1 cycle. Expect: done after 32 cycles; nexthop=7; bestq=40; nextsinks=65.
2. In-cluster sink and no better hop. Setup: count=2, myQ=50, myCl=1, entries (12,30,4,1), (14,10,1,1). Expect: nexthop=65; bestq=50; nextsinks=14, because ID 12's sink is in another cluster.
3. Empty table. Setup: count=0. Expect: done after exactly 8 cycles; nexthop=65; nextsinks=65; no reads at NEIGH_BASE.
4. Count clamp. Setup: count=40 (> MAX_NEIGH=16), best entry at index 15. Expect: only 16 entries read; done at 136 cycles; nexthop = ID of entry 15.
5. Reset and done handshake.
   - nrst=0 during an E_Q state: expect rd_en=0, done=0, nexthop=65 on the next edge.
   - Restart with start held high: done stays 1.
   - Drop start: done=0 on the next edge.
6. Exploration (FIND_NEXT_HOP_EXPLORE_EN). Setup: table of test 1, rng_in=16'h0105. Expect: nexthop=7, explored=1 (idx 1).
   - rng_in=16'h0550: greedy result, explored=0.
   - rng_in=16'h0805: idx 8 >= N, so greedy result, explored=0.
